// File: rtl/multu_hilo_unit.sv
// Multi-cycle unsigned multiplier (radix-2 shift-add) with the HI/LO register pair.
// Latency: HI/LO show the new product WIDTH cycles after the issuing edge; busy is high for WIDTH cycles.
// Backpressure: stall is raised combinationally when MULTU/MFHI/MFLO meets a busy unit.
module multu_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hilo_we,
    input  logic             hilo_rd,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Counter value seen on the final iteration edge.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [0:0]       state_q,  state_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH:0]   acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    logic             done_q,   done_d;

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   acc_nx;
    logic [WIDTH-1:0] mplier_nx;

    // One shift-add iteration: add mcand when the multiplier LSB is set, then shift
    // {acc, mplier} right by one so the low product bits accumulate in mplier.
    always_comb begin
        sum       = acc_q + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
        shifted   = {sum, mplier_q} >> 1;
        acc_nx    = shifted[2*WIDTH:WIDTH];
        mplier_nx = shifted[WIDTH-1:0];
    end

    // Next-state logic: accept MULTU only when idle; HI/LO are written only on the last iteration.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hilo_we) begin
                    mcand_d  = src_a;
                    mplier_d = src_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_nx;
                mplier_d = mplier_nx;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    hi_d    = acc_nx[WIDTH-1:0];
                    lo_d    = mplier_nx;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any multiply in flight and clears HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // Outputs: stall only holds HI/LO users; unrelated instructions flow past a busy unit.
    always_comb begin
        hi    = hi_q;
        lo    = lo_q;
        busy  = (state_q == S_RUN);
        done  = done_q;
        stall = busy & (hilo_we | hilo_rd);
    end

endmodule

// File: tb/tb_multu_hilo_unit.sv
module tb_multu_hilo_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             hilo_we = 1'b0;
    logic             hilo_rd = 1'b0;
    logic [WIDTH-1:0] src_a = '0;
    logic [WIDTH-1:0] src_b = '0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    multu_hilo_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .hilo_we(hilo_we),
        .hilo_rd(hilo_rd),
        .src_a  (src_a),
        .src_b  (src_b),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles of work remaining, expected done strobe, pending products.
    int          left     = 0;
    bit          exp_done = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] last_prod = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of issue acceptance and completion, evaluated on the same edges as the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            left      = 0;
            exp_done  = 1'b0;
            last_prod = '0;
            exp_q.delete();
        end else begin
            exp_done = 1'b0;
            if (left > 0) begin
                left--;
                if (left == 0) exp_done = 1'b1;
            end else if (hilo_we) begin
                left = WIDTH;
                exp_q.push_back({32'b0, src_a} * {32'b0, src_b});
            end
        end
    end

    // Monitor: compare handshake outputs every cycle, and the product when it is due.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("busy", {63'b0, busy}, {63'b0, (left > 0)});
            chk("done", {63'b0, done}, {63'b0, exp_done});
            chk("stall", {63'b0, stall}, {63'b0, ((left > 0) && (hilo_we || hilo_rd))});
            if (left > 0) begin
                chk("hilo_hold", {hi, lo}, last_prod);
            end
            if (exp_done) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 64'd0, 64'd1);
                end else begin
                    last_prod = exp_q.pop_front();
                    chk("product", {hi, lo}, last_prod);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", {63'b0, busy}, 64'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        src_a   = a;
        src_b   = b;
        hilo_we = 1'b1;
        tick();
        hilo_we = 1'b0;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
        issue(a, b);
        wait_idle();
    endtask

    initial begin
        int n;
        logic [31:0] a;
        logic [31:0] b;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        hilo_rd = 1'b1;
        #1;
        chk("rst_stall", {63'b0, stall}, 64'd0);
        hilo_rd = 1'b0;
        rst = 1'b0;
        tick();

        // 7*6 with latency count
        issue(32'd7, 32'd6);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'd32);
        chk("t1_prod", {hi, lo}, 64'h0000_0000_0000_002A);
        tick();
        chk("t1_done_pulse", {63'b0, done}, 64'd0);

        // Corner operands
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("t2_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_mul(32'h8000_0000, 32'd2);
        chk("t2_msb", {hi, lo}, 64'h0000_0001_0000_0000);
        run_mul(32'd0, 32'hDEAD_BEEF);
        chk("t2_zero", {hi, lo}, 64'd0);

        // Reads held while busy
        issue(32'd3, 32'd5);
        repeat (4) tick();
        hilo_rd = 1'b1;
        repeat (36) tick();
        hilo_rd = 1'b0;
        chk("t3_prod", {hi, lo}, 64'd15);

        // MULTU held through busy is accepted on the done cycle
        issue(32'd3, 32'd5);
        src_a   = 32'd9;
        src_b   = 32'd9;
        hilo_we = 1'b1;
        repeat (WIDTH + 1) tick();
        hilo_we = 1'b0;
        wait_idle();
        chk("t4_prod", {hi, lo}, 64'd81);

        // Async reset mid-multiply
        issue(32'h1234, 32'h5678);
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_hi", {32'b0, hi}, 64'd0);
        chk("t5_lo", {32'b0, lo}, 64'd0);
        chk("t5_busy", {63'b0, busy}, 64'd0);
        chk("t5_done", {63'b0, done}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        run_mul(32'h1234, 32'h5678);
        chk("t5_after", {hi, lo}, 64'h0000_0000_0626_0060);

        // Randomised operands, gaps, read traffic and operand churn during busy
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0: a = 32'hFFFF_FFFF;
                1: a = 32'd0;
                default: a = $urandom;
            endcase
            b = (i % 9 == 0) ? 32'hFFFF_FFFF : $urandom;
            issue(a, b);
            n = 0;
            while (busy !== 1'b0 && n < 200) begin
                src_a   = $urandom;
                src_b   = $urandom;
                hilo_rd = $urandom_range(0, 1);
                tick();
                n++;
            end
            chk("rand_idle", {63'b0, busy}, 64'd0);
            hilo_rd = $urandom_range(0, 1);
            repeat ($urandom_range(0, 3)) tick();
            hilo_rd = 1'b0;
        end
        tick();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
